// File: rtl/bch_syndrome_gen.sv
// Parallel BCH syndrome generator over GF(2^13), poly x^13+x^4+x^3+x+1.
// Consumes P codeword bits per accepted word and Horner-accumulates S_1..S_2T.
// Optional build macro BCH_SYN_SQUARE_EN: only odd accumulators are built and
// even syndromes are derived at load time by squaring (S_2i = S_i^2).
module bch_syndrome_gen #(
  parameter int unsigned P = 32,
  parameter int unsigned T = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [P-1:0]          in_data,
  output logic                  in_ready,
  output logic                  syn_valid,
  input  logic                  syn_ready,
  output logic [13*2*T-1:0]     syn_data,
  output logic                  syn_zero
);

  localparam int unsigned M    = 13;
  localparam int unsigned NSyn = 2 * T;
  localparam logic [M-1:0] PolyLow = 13'h001B;
`ifdef BCH_SYN_SQUARE_EN
  localparam int unsigned Stride = 2;
`else
  localparam int unsigned Stride = 1;
`endif
  localparam int unsigned NAcc = NSyn / Stride;
  // Per-syndrome table: entries 0..P-1 hold alpha^(j*k), entries P..P+12 hold alpha^(jP+i).
  localparam int unsigned TabW = M * (P + M);

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PolyLow : '0);
  endfunction

  function automatic logic [TabW-1:0] pow_tab(input int unsigned j);
    logic [TabW-1:0] tab;
    logic [M-1:0]    cur;
    tab = '0;
    cur = 13'd1;
    for (int unsigned k = 0; k < P; k++) begin
      tab[M*k +: M] = cur;
      for (int unsigned n = 0; n < j; n++) cur = mul_alpha(cur);
    end
    for (int unsigned i = 0; i < M; i++) begin
      tab[M*(P+i) +: M] = cur;
      cur = mul_alpha(cur);
    end
    return tab;
  endfunction

  logic [M*NAcc-1:0] r_acc;
  logic [M*NAcc-1:0] w_acc_nxt;
  logic [M*NSyn-1:0] w_syn;
  logic [M*NSyn-1:0] r_syn_data;
  logic              r_syn_valid;
  logic              r_syn_zero;
  logic              w_accept;

  // No in_valid term: ready depends only on registered state and syn_ready.
  assign in_ready  = !r_syn_valid || syn_ready;
  assign w_accept  = in_valid && in_ready;
  assign syn_valid = r_syn_valid;
  assign syn_data  = r_syn_data;
  assign syn_zero  = r_syn_zero;

  for (genvar m = 0; m < NAcc; m++) begin : g_acc
    localparam logic [TabW-1:0] Tab = pow_tab(Stride * m + 1);
    logic [M-1:0] w_nxt;

    // Constant-multiplier XOR network: A*alpha^(jP) folded with the word's own contribution.
    always_comb begin
      w_nxt = '0;
      if (!in_first) begin
        for (int unsigned i = 0; i < M; i++) begin
          if (r_acc[M*m+i]) w_nxt = w_nxt ^ Tab[M*(P+i) +: M];
        end
      end
      for (int unsigned k = 0; k < P; k++) begin
        if (in_data[k]) w_nxt = w_nxt ^ Tab[M*k +: M];
      end
    end

    assign w_acc_nxt[M*m +: M] = w_nxt;
  end

`ifdef BCH_SYN_SQUARE_EN
  function automatic logic [M*M-1:0] sq_tab();
    logic [M*M-1:0] tab;
    logic [M-1:0]   cur;
    tab = '0;
    cur = 13'd1;
    for (int unsigned i = 0; i < M; i++) begin
      tab[M*i +: M] = cur;
      cur = mul_alpha(mul_alpha(cur));
    end
    return tab;
  endfunction

  localparam logic [M*M-1:0] SqTab = sq_tab();

  // Squaring is linear over GF(2): XOR of alpha^(2i) for each set bit i.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [M-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (a[i]) r = r ^ SqTab[M*i +: M];
    end
    return r;
  endfunction

  // Odd syndromes come straight from the accumulators; even ones chain squarings.
  always_comb begin
    logic [M*NSyn-1:0] s;
    s = '0;
    for (int unsigned j = 1; j <= NSyn; j++) begin
      if (j % 2 == 0) s[M*(j-1) +: M] = gf_sq(s[M*(j/2-1) +: M]);
      else            s[M*(j-1) +: M] = w_acc_nxt[M*((j-1)/2) +: M];
    end
    w_syn = s;
  end
`else
  assign w_syn = w_acc_nxt;
`endif

  // Accumulators advance only on accepted words, so back-pressure freezes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
    end
  end

  // Output register: load on accepted last word, else drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_syn_valid <= 1'b0;
      r_syn_data  <= '0;
      r_syn_zero  <= 1'b0;
    end else if (w_accept && in_last) begin
      r_syn_valid <= 1'b1;
      r_syn_data  <= w_syn;
      r_syn_zero  <= (w_syn == '0);
    end else if (syn_ready) begin
      r_syn_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bch_syndrome_gen.sv
// Scoreboard bench for bch_syndrome_gen (P=32, T=8).
module tb_bch_syndrome_gen;

  localparam int unsigned P  = 32;
  localparam int unsigned T  = 8;
  localparam int unsigned NS = 2 * T;
  localparam int unsigned W  = 13 * NS;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_first  = 1'b0;
  logic         in_last   = 1'b0;
  logic [P-1:0] in_data   = '0;
  logic         in_ready;
  logic         syn_valid;
  logic         syn_ready = 1'b1;
  logic [W-1:0] syn_data;
  logic         syn_zero;

  always #5 clk = ~clk;

  bch_syndrome_gen #(.P(P), .T(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_data  (syn_data),
    .syn_zero  (syn_zero)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_data_q[$];
  logic         exp_zero_q[$];
  logic [12:0]  exp_tab[0:8190];
  logic [P-1:0] cw[$];
  logic [W-1:0] all_ones;
  logic [W-1:0] deg1_syn;
  logic [W-1:0] mon_ed;
  logic         mon_ez;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Direct evaluation: S_j = XOR over set bits of alpha^(j*degree).
  function automatic logic [W-1:0] model();
    logic [W-1:0] res;
    logic [12:0]  s;
    int           n;
    int           d;
    res = '0;
    n   = cw.size();
    for (int j = 1; j <= NS; j++) begin
      s = '0;
      for (int w = 0; w < n; w++) begin
        for (int k = 0; k < P; k++) begin
          if (cw[w][k]) begin
            d = (n - 1 - w) * P + k;
            s = s ^ exp_tab[(j * d) % 8191];
          end
        end
      end
      res[13*(j-1) +: 13] = s;
    end
    return res;
  endfunction

  // Monitor: every consumed syndrome set is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && syn_valid && syn_ready) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_syndrome: actual=%h required=none", syn_data);
      end else begin
        mon_ed = exp_data_q.pop_front();
        mon_ez = exp_zero_q.pop_front();
        check("syn_data", syn_data, mon_ed);
        check("syn_zero", W'(syn_zero), W'(mon_ez));
      end
    end
  end

  task automatic send_word(input logic [P-1:0] d, input logic f, input logic l,
                           input logic [W-1:0] ed, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (l) begin
          exp_data_q.push_back(ed);
          exp_zero_q.push_back(ed == '0);
        end
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: actual=not_accepted required=accepted");
    end
  endtask

  task automatic send_cw(input logic use_first, input logic [W-1:0] ed, output int stalls);
    int s;
    stalls = 0;
    for (int w = 0; w < cw.size(); w++) begin
      send_word(cw[w], use_first && (w == 0), w == cw.size() - 1, ed, s);
      stalls += s;
    end
  endtask

  task automatic load_single(input int nwords, input logic [P-1:0] last_word);
    cw.delete();
    for (int w = 0; w < nwords - 1; w++) cw.push_back('0);
    cw.push_back(last_word);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int st;
    int total;
    int lens[6];
    lens = '{8, 8, 1, 3, 8, 2};

    e = 1;
    for (int i = 0; i < 8191; i++) begin
      exp_tab[i] = 13'(e);
      e = e << 1;
      if ((e & 'h2000) != 0) e = e ^ 'h201B;
    end
    for (int j = 0; j < NS; j++) all_ones[13*j +: 13] = 13'h0001;
    deg1_syn = {13'h00D8, 13'h006C, 13'h0036, 13'h001B, 13'h1000, 13'h0800, 13'h0400,
                13'h0200, 13'h0100, 13'h0080, 13'h0040, 13'h0020, 13'h0010, 13'h0008,
                13'h0004, 13'h0002};

    // Reset state, with syn_ready low so in_ready reflects !syn_valid
    syn_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1'b1));
    check("reset_syn_valid", W'(syn_valid), W'(1'b0));
    check("reset_syn_data", syn_data, '0);
    check("reset_syn_zero", W'(syn_zero), W'(1'b0));
    @(posedge clk);
    #1;
    syn_ready = 1'b1;

    // All-zero codeword
    load_single(8, 32'h0);
    send_cw(1'b1, '0, st);
    // Single error at degree 0
    load_single(8, 32'h1);
    send_cw(1'b1, all_ones, st);
    // Single error at degree 1
    load_single(8, 32'h2);
    send_cw(1'b1, deg1_syn, st);
    // Single-word codewords (first and last together)
    load_single(1, 32'h2);
    send_cw(1'b1, deg1_syn, st);
    load_single(1, 32'h3);
    send_cw(1'b1, all_ones ^ deg1_syn, st);

    // Partial codeword abandoned by a fresh in_first
    send_word(32'hA5A5_1234, 1'b1, 1'b0, '0, st);
    send_word(32'h0F0F_FFFF, 1'b0, 1'b0, '0, st);
    send_word(32'h8000_0001, 1'b0, 1'b0, '0, st);
    load_single(8, 32'h1);
    send_cw(1'b1, all_ones, st);

    // Back-to-back pseudo-random codewords against the GF model
    total = 0;
    for (int c = 0; c < 6; c++) begin
      cw.delete();
      for (int w = 0; w < lens[c]; w++) cw.push_back(P'($urandom));
      send_cw(1'b1, model(), st);
      total += st;
    end
    check("no_stall_streaming", W'(total), '0);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: output held, input blocked, even with a last word offered
    syn_ready = 1'b0;
    load_single(8, 32'h1);
    send_cw(1'b1, all_ones, st);
    in_valid = 1'b1;
    in_first = 1'b0;
    in_last  = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_syn_valid", W'(syn_valid), W'(1'b1));
      check("bp_in_ready", W'(in_ready), W'(1'b0));
      check("bp_syn_data", syn_data, all_ones);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    syn_ready = 1'b1;
    load_single(1, 32'h2);
    send_cw(1'b1, deg1_syn, st);
    check("accept_on_ready_rise", W'(st), '0);
    repeat (3) @(posedge clk);
    #1;

    // Reset with a pending syndrome set: it is lost immediately
    syn_ready = 1'b0;
    load_single(1, 32'h1);
    send_cw(1'b1, all_ones, st);
    rst = 1'b1;
    exp_data_q.delete();
    exp_zero_q.delete();
    #1;
    check("rst_syn_valid", W'(syn_valid), W'(1'b0));
    check("rst_syn_data", syn_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    syn_ready = 1'b1;

    // Reset mid-codeword, then a codeword without in_first relies on A being cleared
    send_word(32'h1234_5678, 1'b1, 1'b0, '0, st);
    send_word(32'hFFFF_0000, 1'b0, 1'b0, '0, st);
    send_word(32'h0000_00FF, 1'b0, 1'b0, '0, st);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_single(8, 32'h1);
    send_cw(1'b0, all_ones, st);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", W'(exp_data_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
